// File: rtl/cbus_arbiter.sv
// Round-robin arbiter granting one of NUM_REQ cache-bus requesters ownership of the
// shared memory bus for a whole burst; request/response paths are pure muxes.

package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs     [NUM_REQ],
  output cbus_resp_t       iresps    [NUM_REQ],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_busy;

  logic [NUM_REQ-1:0] w_valid;
  logic [NUM_REQ-1:0] w_cand_valid;
  logic [IDX_W-1:0]   w_cand_idx [NUM_REQ];
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_any_valid;
  logic               w_fwd;
  logic               w_release;

  // Forwarding is also gated by reset so nothing leaks out while reset is held.
  assign w_fwd     = (r_state == S_BUSY) && !reset;
  assign w_release = oresp.ready && oresp.last;

  // Candidate gi is the requester gi+1 places after the last owner, wrapping at NUM_REQ.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic [IDX_W:0] w_sum;

    assign w_valid[gi]      = ireqs[gi].valid;
    assign w_sum            = {1'b0, r_rr_ptr} + (IDX_W+1)'(gi + 1);
    assign w_cand_idx[gi]   = (w_sum >= (IDX_W+1)'(NUM_REQ))
                              ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                              : IDX_W'(w_sum);
    assign w_cand_valid[gi] = w_valid[w_cand_idx[gi]];
    assign iresps[gi]       = (w_fwd && (r_grant_idx == IDX_W'(gi))) ? oresp : '0;
  end

  assign w_any_valid = |w_valid;

  // Scan farthest-first so the nearest valid candidate overwrites the rest.
  always_comb begin
    w_pick_idx = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (w_cand_valid[j]) begin
        w_pick_idx = w_cand_idx[j];
      end
    end
  end

  assign oreq      = w_fwd ? ireqs[r_grant_idx] : '0;
  assign grant_idx = r_grant_idx;
  assign busy      = r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
      r_grant_idx <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_valid) begin
            r_state     <= S_BUSY;
            r_grant_idx <= w_pick_idx;
            r_busy      <= 1'b1;
          end
        end
        S_BUSY: begin
          // Held until the last beat, even if the owner drops valid mid-burst.
          if (w_release) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= r_grant_idx;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: single read, tie, fairness, no preemption,
// reset mid-burst and spurious responses, all with hand-computed expectations.

module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int NUM_REQ = 2;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireqs  [NUM_REQ];
  cbus_resp_t iresps [NUM_REQ];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic [0:0] grant_idx;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  cbus_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic [31:0] addr, input logic [7:0] len);
    ireqs[idx].valid    = v;
    ireqs[idx].is_write = 1'b0;
    ireqs[idx].size     = 2'd2;
    ireqs[idx].addr     = addr;
    ireqs[idx].strobe   = 4'hF;
    ireqs[idx].data     = 32'h0;
    ireqs[idx].len      = len;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_oreq_zero"}, 64'(oreq == '0), 64'd1);
    for (int i = 0; i < NUM_REQ; i++) begin
      check({tag, "_iresp_zero"}, 64'(iresps[i] == '0), 64'd1);
    end
  endtask

  // One response beat to owner idx; the edge at the end of the task consumes it.
  task automatic beat(input int idx, input int n, input logic last, input logic [31:0] exp_addr);
    logic [31:0] exp_data;
    exp_data    = 32'hD000_0000 | 32'(n);
    oresp.ready = 1'b1;
    oresp.last  = last;
    oresp.data  = exp_data;
    #1;
    check("beat_busy", 64'(busy), 64'd1);
    check("beat_gidx", 64'(grant_idx), 64'(idx));
    check("beat_oreq_addr", 64'(oreq.addr), 64'(exp_addr));
    check("beat_rdata", 64'(iresps[idx].data), 64'(exp_data));
    check("beat_rlast", 64'(iresps[idx].last), 64'(last));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i != idx) check("beat_other_zero", 64'(iresps[i] == '0), 64'd1);
    end
    step();
    oresp = '0;
  endtask

  task automatic burst(input int idx, input int nbeats, input logic [31:0] addr, input logic drop);
    for (int n = 0; n < nbeats; n++) begin
      beat(idx, n, (n == nbeats - 1), addr);
    end
    if (drop) ireqs[idx].valid = 1'b0;
    #1;
    check("release_busy", 64'(busy), 64'd0);
    $display("txn: owner=%0d beats=%0d addr=0x%08h", idx, nbeats, addr);
  endtask

  task automatic wait_busy(input int max_cycles);
    int c;
    c = 0;
    while (!busy && c < max_cycles) begin
      step();
      c++;
    end
    check("wait_busy", 64'(busy), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt [NUM_REQ];
    int g;

    reset = 1'b1;
    oresp = '0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 32'h0, 8'd0);
    step();
    step();

    // Reset state, with a valid request that must not leak through.
    set_req(0, 1'b1, 32'h0000_1000, 8'd0);
    #1;
    check("rst_oreq_valid", 64'(oreq.valid), 64'd0);
    check_idle("rst");
    check("rst_gidx", 64'(grant_idx), 64'd0);
    step();
    check("rst_hold_busy", 64'(busy), 64'd0);
    ireqs[0].valid = 1'b0;
    reset = 1'b0;
    step();
    check_idle("post_rst");

    // Single read, 16 beats, 1 cycle grant latency.
    set_req(1, 1'b1, 32'h8000_0040, 8'd15);
    #1;
    check("rd_lat_oreq_valid", 64'(oreq.valid), 64'd0);
    step();
    check("rd_busy", 64'(busy), 64'd1);
    check("rd_gidx", 64'(grant_idx), 64'd1);
    check("rd_oreq_valid", 64'(oreq.valid), 64'd1);
    check("rd_oreq_len", 64'(oreq.len), 64'd15);
    burst(1, 16, 32'h8000_0040, 1'b1);
    check_idle("rd_done");

    // Tie after reset: 0 wins, 1 follows after a one-cycle bubble.
    pulse_reset();
    set_req(0, 1'b1, 32'h0000_1000, 8'd1);
    set_req(1, 1'b1, 32'h0000_2000, 8'd1);
    step();
    check("tie_first_gidx", 64'(grant_idx), 64'd0);
    burst(0, 2, 32'h0000_1000, 1'b1);
    check_idle("tie_bubble");
    step();
    check("tie_second_busy", 64'(busy), 64'd1);
    check("tie_second_gidx", 64'(grant_idx), 64'd1);
    burst(1, 2, 32'h0000_2000, 1'b1);

    // Fairness with both requesters continuously valid.
    pulse_reset();
    set_req(0, 1'b1, 32'h0000_3000, 8'd3);
    set_req(1, 1'b1, 32'h0000_3100, 8'd3);
    for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
    for (int t = 0; t < 8; t++) begin
      wait_busy(4);
      check("fair_order", 64'(grant_idx), 64'(t % 2));
      g = int'(grant_idx);
      cnt[g]++;
      burst(g, 4, (g == 0) ? 32'h0000_3000 : 32'h0000_3100, 1'b0);
    end
    ireqs[0].valid = 1'b0;
    ireqs[1].valid = 1'b0;
    check("fair_cnt0", 64'(cnt[0]), 64'd4);
    check("fair_cnt1", 64'(cnt[1]), 64'd4);

    // No preemption: requester 1 arrives mid-burst of requester 0.
    step();
    set_req(0, 1'b1, 32'h0000_4000, 8'd15);
    step();
    check("nopre_gidx", 64'(grant_idx), 64'd0);
    for (int n = 0; n < 16; n++) begin
      if (n == 3) set_req(1, 1'b1, 32'h0000_5000, 8'd0);
      beat(0, n, (n == 15), 32'h0000_4000);
    end
    ireqs[0].valid = 1'b0;
    #1;
    check("nopre_release", 64'(busy), 64'd0);
    $display("txn: owner=0 beats=16 addr=0x00004000");
    step();
    check("nopre_next_gidx", 64'(grant_idx), 64'd1);
    burst(1, 1, 32'h0000_5000, 1'b1);

    // Reset at beat 5 of 16 abandons the burst.
    set_req(0, 1'b1, 32'h0000_6000, 8'd15);
    step();
    check("rstmid_gidx", 64'(grant_idx), 64'd0);
    for (int n = 0; n < 5; n++) beat(0, n, 1'b0, 32'h0000_6000);
    reset       = 1'b1;
    oresp.ready = 1'b1;
    oresp.data  = 32'hD000_0005;
    #1;
    check("rstmid_gate_oreq", 64'(oreq.valid), 64'd0);
    check("rstmid_gate_iresp", 64'(iresps[0] == '0), 64'd1);
    step();
    reset = 1'b0;
    oresp = '0;
    ireqs[0].valid = 1'b0;
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_oreq_valid", 64'(oreq.valid), 64'd0);
    $display("txn: owner=0 abandoned by reset after 5 beats");
    set_req(1, 1'b1, 32'h0000_7000, 8'd0);
    #1;
    check("rstmid_fresh_lat", 64'(busy), 64'd0);
    step();
    check("rstmid_fresh_busy", 64'(busy), 64'd1);
    check("rstmid_fresh_gidx", 64'(grant_idx), 64'd1);
    burst(1, 1, 32'h0000_7000, 1'b1);

    // Spurious ready/last while idle: ignored, rr pointer untouched.
    pulse_reset();
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 32'hBAD0_BAD0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_idle("spur");
      step();
    end
    oresp = '0;
    set_req(0, 1'b1, 32'h0000_8000, 8'd0);
    set_req(1, 1'b1, 32'h0000_9000, 8'd0);
    step();
    check("spur_rr_gidx", 64'(grant_idx), 64'd0);
    burst(0, 1, 32'h0000_8000, 1'b1);
    ireqs[1].valid = 1'b0;
    step();
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of cache-bus requesters (index 0 = ICache, 1 = DCache); the legal range is 2..4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port ireqs, input, NUM_REQ x cbus_req_t: per-requester bus request {valid, is_write, size, addr, strobe, data, len}.
REQ-005 The block SHALL have port iresps, output, NUM_REQ x cbus_resp_t: per-requester response {ready, last, data}.
REQ-006 The block SHALL have port oreq, output, cbus_req_t: the request forwarded to the shared memory bus.
REQ-007 The block SHALL have port oresp, input, cbus_resp_t: the response from the shared memory bus.
REQ-008 The block SHALL have port grant_idx, output, clog2(NUM_REQ) bits: the index of the currently owning requester (debug/perf counters); valid only while busy=1.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a transaction owns the bus.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no owner) and BUSY (owner = grant_idx).
REQ-011 In IDLE, oreq SHALL be all-zero and every iresps entry SHALL be all-zero.
REQ-012 In IDLE, if any ireqs[i].valid is high, the block SHALL select one requester round-robin, starting from the index after the last completed owner (rr_ptr), and enter BUSY on the next edge with grant_idx = that index.
REQ-013 The grant decision SHALL be registered, giving exactly 1 cycle of added latency from valid to oreq.valid.
REQ-014 In BUSY, oreq SHALL equal ireqs[grant_idx] combinationally.
REQ-015 In BUSY, iresps[grant_idx] SHALL equal oresp, and all other iresps entries SHALL be all-zero.
REQ-016 Ownership SHALL be held for the whole burst, for len+1 beats, with no preemption.
REQ-017 Transition BUSY -> IDLE SHALL occur on the cycle where oresp.ready=1 and oresp.last=1; on the same edge rr_ptr SHALL be set to grant_idx.
REQ-018 After release, the block SHALL spend at least one cycle in IDLE; back-to-back owners SHALL therefore see a 1-cycle bubble.
REQ-019 If the owner deasserts valid while BUSY (a protocol violation), the block SHALL keep ownership and forward the request, which now has valid=0, until the last beat or reset; it SHALL NOT re-arbitrate.
REQ-020 oresp.ready or oresp.last arriving while IDLE SHALL be ignored and SHALL NOT change state.
REQ-021 When requesters arrive in the same cycle, arbitration SHALL be fair: with all NUM_REQ requesting continuously, each SHALL be granted exactly once per NUM_REQ grants.
REQ-022 rr_ptr wrap-around: index NUM_REQ-1 SHALL be followed by index 0.
REQ-023 The block SHALL hold no data buffering; the data path SHALL be pure muxing, and only the FSM, grant_idx and rr_ptr SHALL be registered.

Reset
REQ-024 On reset=1 at a rising edge, the block SHALL set the FSM to IDLE, rr_ptr to NUM_REQ-1 (so index 0 wins the first tie), grant_idx to 0 and busy to 0.
REQ-025 Reset asserted mid-burst SHALL abandon the transaction immediately: outputs all-zero from the next cycle, with no completion response.
REQ-026 While reset=1, oreq.valid SHALL be 0 and all iresps SHALL be zero, regardless of ireqs.

Verification
REQ-027 Single read: ireqs[1] = {valid=1, addr=0x8000_0040, len=15} -> oreq.valid rises 1 cycle later; 16 ready beats forwarded to iresps[1] only; busy falls after the beat with last=1.
REQ-028 Tie after reset: ireqs[0] and ireqs[1] both valid in cycle 0 -> index 0 granted; index 1 granted in the first IDLE cycle after index 0's last beat, preceded by a 1-cycle bubble.
REQ-029 Fairness: both requesters held valid for 8 transactions of len=3 -> grants alternate 0,1,0,1,...; each gets 4.
REQ-030 No preemption: index 1 asserts valid mid-burst of index 0 (len=15) -> oreq stays on index 0 for all 16 beats; iresps[1] stays zero throughout.
REQ-031 Reset mid-burst: reset pulsed at beat 5 of 16 -> busy=0 and oreq.valid=0 the next cycle; a fresh request is then granted normally 1 cycle after valid.
REQ-032 Spurious response: oresp.ready=1 and oresp.last=1 while IDLE with no valid requesters -> state stays IDLE, rr_ptr unchanged, and all iresps stay zero.
